// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request at a time,
// buffers the returned word for decode and handles redirects.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_o,
  output logic        fetch_misalign_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_inst;
  logic [31:0] w_inst_nxt;
  logic [31:0] r_inst_pc;
  logic [31:0] w_inst_pc_nxt;
  logic        r_misalign;
  logic [31:0] w_redir_pc;

  assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_inst_nxt    = r_inst;
    w_inst_pc_nxt = r_inst_pc;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        // An accepted request must be drained if we redirect in the same cycle.
        if (imem_gnt_i) w_state_nxt = redirect_i ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          if (redirect_i) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt   = S_HOLD;
            w_inst_nxt    = imem_rdata_i;
            w_inst_pc_nxt = r_pc;
            w_pc_nxt      = r_pc + 32'd4;
          end
        end else if (redirect_i) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (redirect_i || !stall_i) w_state_nxt = S_REQ;
      end
      S_DRAIN: begin
        if (imem_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (redirect_i) w_pc_nxt = w_redir_pc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_inst     <= 32'h0;
      r_inst_pc  <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_inst     <= w_inst_nxt;
      r_inst_pc  <= w_inst_pc_nxt;
      r_misalign <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
    end
  end

  assign imem_req_o       = (r_state == S_REQ);
  assign inst_valid_o     = (r_state == S_HOLD);
  assign imem_addr_o      = r_pc;
  assign pc_o             = r_pc;
  assign inst_o           = r_inst;
  assign inst_pc_o        = r_inst_pc;
  assign fetch_misalign_o = r_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and randomized bench for fetch_ctrl against a transaction-level
// model (outstanding/discard/buffer flags) of the fetch protocol.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  logic        imem_req_o, inst_valid_o, fetch_misalign_o;
  logic [31:0] imem_addr_o, inst_o, inst_pc_o, pc_o;
  logic        w2_req, w2_valid, w2_mis;
  logic [31:0] w2_addr, w2_inst, w2_inst_pc, w2_pc;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] RST_A = 32'h0000_1000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  fetch_ctrl #(.RESET_PC(RST_A)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o), .pc_o(pc_o),
    .fetch_misalign_o(fetch_misalign_o)
  );

  fetch_ctrl #(.RESET_PC(RST_B)) dut_wrap (
    .clk(clk), .reset(reset), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(w2_req), .imem_addr_o(w2_addr),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(w2_valid), .inst_o(w2_inst), .inst_pc_o(w2_inst_pc), .pc_o(w2_pc),
    .fetch_misalign_o(w2_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: started / request outstanding / its response to be dropped / word buffered
  bit          m_idle, m_busy, m_drop, m_hold, m_mis;
  logic [31:0] m_pc, m_inst, m_ipc;

  task automatic model_step();
    logic [31:0] npc;
    if (reset) begin
      m_idle = 1; m_busy = 0; m_drop = 0; m_hold = 0; m_mis = 0;
      m_pc = RST_A; m_inst = 32'h0; m_ipc = 32'h0;
      return;
    end
    npc   = m_pc;
    m_mis = redirect_i && (redirect_pc_i % 4 != 0);
    if (m_idle) begin
      m_idle = 0;
    end else if (m_hold) begin
      if (redirect_i || !stall_i) m_hold = 0;
    end else if (!m_busy) begin
      if (imem_gnt_i) begin
        m_busy = 1;
        m_drop = redirect_i;
      end
    end else if (imem_rvalid_i) begin
      m_busy = 0;
      if (!m_drop && !redirect_i) begin
        m_hold = 1; m_inst = imem_rdata_i; m_ipc = m_pc; npc = m_pc + 4;
      end
      m_drop = 0;
    end else if (redirect_i) begin
      m_drop = 1;
    end
    if (redirect_i) npc = redirect_pc_i - (redirect_pc_i % 4);
    m_pc = npc;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("req",      {31'h0, imem_req_o},       {31'h0, !m_idle && !m_busy && !m_hold});
    chk("addr",     imem_addr_o,               m_pc);
    chk("pc",       pc_o,                      m_pc);
    chk("valid",    {31'h0, inst_valid_o},     {31'h0, m_hold});
    chk("inst",     inst_o,                    m_inst);
    chk("inst_pc",  inst_pc_o,                 m_ipc);
    chk("misalign", {31'h0, fetch_misalign_o}, {31'h0, m_mis});
  endtask

  task automatic cycle(input bit rst, input bit gnt, input bit rv, input logic [31:0] rd,
                       input bit rdr, input logic [31:0] rpc, input bit st);
    reset = rst; imem_gnt_i = gnt; imem_rvalid_i = rv; imem_rdata_i = rd;
    redirect_i = rdr; redirect_pc_i = rpc; stall_i = st;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] held;
    // Reset
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("rst_req",    {31'h0, imem_req_o}, 32'h0);
    chk("rst_addr",   imem_addr_o, RST_A);
    chk("rst_valid",  {31'h0, inst_valid_o}, 32'h0);
    chk("rst_inst",   inst_o, 32'h0);
    chk("rst_mis",    {31'h0, fetch_misalign_o}, 32'h0);
    chk("w_rst_addr", w2_addr, RST_B);
    chk("w_rst_out",  {29'h0, w2_req, w2_valid, w2_mis}, 32'h0);
    // First fetch
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("first_req", {31'h0, imem_req_o}, 32'h1);
    cycle(0, 1, 0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h0010_0093, 0, 0, 1);
    chk("f_valid",   {31'h0, inst_valid_o}, 32'h1);
    chk("f_inst",    inst_o, 32'h0010_0093);
    chk("f_inst_pc", inst_pc_o, 32'h0000_1000);
    chk("f_pc",      pc_o, 32'h0000_1004);
    chk("w_inst_pc", w2_inst_pc, 32'hFFFF_FFFC);
    chk("w_pc",      w2_pc, 32'h0000_0000);
    chk("w_inst",    w2_inst, 32'h0010_0093);
    chk("w_addr",    w2_addr, 32'h0000_0000);
    // Stall in HOLD for 5 cycles
    held = inst_o;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, i[0], 32'h1234_5678, 0, 0, 1);
      chk("stall_inst", inst_o, held);
      chk("stall_req",  {31'h0, imem_req_o}, 32'h0);
    end
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("post_stall_req",  {31'h0, imem_req_o}, 32'h1);
    chk("post_stall_addr", imem_addr_o, 32'h0000_1004);
    // Redirect in WAIT, orphan response 3 cycles later
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 32'h0000_0200, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("drain_req", {31'h0, imem_req_o}, 32'h0);
    cycle(0, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("drain_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("drain_addr",  imem_addr_o, 32'h0000_0200);
    // Redirect with gnt in REQ
    cycle(0, 1, 0, 0, 1, 32'h0000_0300, 0);
    chk("rg_req", {31'h0, imem_req_o}, 32'h0);
    cycle(0, 0, 1, 32'hCAFE_F00D, 0, 0, 0);
    chk("rg_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("rg_addr",  imem_addr_o, 32'h0000_0300);
    // Redirect in HOLD with stall low
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 32'h0000_0013, 0, 0, 0);
    chk("h_inst_pc", inst_pc_o, 32'h0000_0300);
    cycle(0, 0, 0, 0, 1, 32'h0000_0400, 0);
    chk("h_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("h_addr",  imem_addr_o, 32'h0000_0400);
    // Misaligned redirect in REQ
    cycle(0, 0, 0, 0, 1, 32'h0000_0106, 0);
    chk("mis_on",   {31'h0, fetch_misalign_o}, 32'h1);
    chk("mis_addr", imem_addr_o, 32'h0000_0104);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("mis_off",  {31'h0, fetch_misalign_o}, 32'h0);
    chk("mis_req",  {31'h0, imem_req_o}, 32'h1);
    // Reset mid-WAIT, late rvalid ignored
    cycle(0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0);
    chk("mr_pc",  pc_o, RST_A);
    chk("mr_req", {31'h0, imem_req_o}, 32'h0);
    cycle(0, 0, 1, 32'hBAD0_BAD0, 0, 0, 0);
    cycle(0, 0, 1, 32'hBAD1_BAD1, 0, 0, 0);
    chk("mr_valid", {31'h0, inst_valid_o}, 32'h0);
    chk("mr_inst",  inst_o, 32'h0);
    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 99) < 50),
            ($urandom_range(0, 99) < 40),
            $urandom,
            ($urandom_range(0, 99) < 10),
            $urandom,
            ($urandom_range(0, 99) < 40));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage of the RV32I core. It owns the 32-bit program-counter register and issues one instruction-memory request at a time. It holds the returned instruction until decode accepts it, and applies branch/jump redirects, discarding any fetch already in flight. It sits between the imem port and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; dominates every other input.
- stall_i  in  1  decode not ready; the held instruction is consumed in a cycle with inst_valid_o=1 and stall_i=0.
- redirect_i  in  1  taken branch/jump/trap; single-cycle pulse.
- redirect_pc_i  in  32  redirect target.
- imem_req_o  out  1  fetch request.
- imem_addr_o  out  32  fetch address (equals pc_o).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response valid.
- imem_rdata_i  in  32  response instruction word.
- inst_valid_o  out  1  inst_o/inst_pc_o valid for decode.
- inst_o  out  32  fetched instruction.
- inst_pc_o  out  32  address of inst_o.
- pc_o  out  32  PC of the next fetch.
- fetch_misalign_o  out  1  one-cycle pulse: a redirect target had bits[1:0]≠0.

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN. Moore outputs: imem_req_o=(state==REQ); inst_valid_o=(state==HOLD); imem_addr_o=pc_o.
- Reset: state=IDLE, pc=RESET_PC, inst_o=0, inst_pc_o=0, fetch_misalign_o=0. All outputs are therefore 0, except pc_o/imem_addr_o, which equal RESET_PC.
- IDLE: unconditional transition to REQ. A redirect in IDLE loads the PC.
- REQ:
  - gnt=1: go to WAIT. This holds even if redirect is high in the same cycle; in that case load the PC and go to DRAIN instead, because the old request was accepted.
  - gnt=0 with redirect: load the PC and stay in REQ.
  - gnt=0 without redirect: stay in REQ.
- WAIT:
  - rvalid with redirect: discard the response, load the PC, go to REQ.
  - rvalid without redirect: inst_o←rdata, inst_pc_o←pc, pc←pc+4, go to HOLD.
  - redirect without rvalid: load the PC, go to DRAIN.
- HOLD: inst_o and inst_pc_o are stable.
  - redirect: load the PC and go to REQ. The held instruction is dropped, even if it was consumed in the same cycle.
  - Otherwise, stall_i=0: consumed, go to REQ.
  - Otherwise, stay in HOLD.
- DRAIN: waits for the orphaned response.
  - rvalid: discard it and go to REQ.
  - A redirect in DRAIN loads the PC; the latest redirect wins.
- PC load rule: pc←{redirect_pc_i[31:2],2'b00}. fetch_misalign_o←|redirect_pc_i[1:0] on any cycle with redirect_i=1 (excluding reset), and is 0 otherwise.
- PC increment is modulo 2^32: 32'hFFFF_FFFC+4 → 32'h0000_0000.
- Protocol-violation inputs are ignored: rvalid in IDLE/REQ/HOLD, and gnt outside REQ.
- Reset mid-fetch returns to IDLE. A response arriving after reset for a pre-reset request is ignored, because it arrives in IDLE or REQ.

## Timing
- One outstanding request maximum. The imem_req_o→gnt handshake may stretch indefinitely; imem_addr_o is stable while req=1 and there is no redirect.
- The first edge with reset=0 moves IDLE→REQ, so imem_req_o rises one cycle after reset deassertion.
- Best case per instruction, with gnt in the first REQ cycle, rvalid in the first WAIT cycle, and no stall: REQ, WAIT, HOLD, i.e. 3 cycles per instruction. The next REQ immediately follows the HOLD cycle.
- inst_valid_o rises the cycle after the rvalid cycle.
- Redirect latency: the new target appears on imem_addr_o the cycle after redirect_i, or after DRAIN completes.
- fetch_misalign_o is registered: it asserts the cycle after the offending redirect, for one cycle.

## Test plan
- Reset with RESET_PC=32'h0000_1000, then gnt immediate and rvalid next cycle with rdata=32'h0010_0093. Required response: imem_req_o is 0 during reset, addr=0x1000. Then inst_valid_o=1, inst_o=0x0010_0093, inst_pc_o=0x1000, pc_o=0x1004. The next request goes to 0x1004.
- Stall: hold stall_i=1 for 5 cycles while in HOLD. Required response: inst_valid_o, inst_o and inst_pc_o stay stable for the whole stall; no imem_req_o. A request to pc+4 issues the cycle after stall_i drops.
- Redirect in WAIT to 0x200, with rvalid 3 cycles later carrying 0xDEAD_BEEF. Required response: DRAIN is entered, the response is discarded (inst_valid_o stays 0), and the next request goes to 0x200.
- Redirect with gnt in the same REQ cycle to 0x300. Required response: DRAIN is entered, the old response is dropped, and the next request goes to 0x300. Repeat with redirect in HOLD while stall_i=0: the held instruction is dropped and the next request goes to the target.
- Wrap: RESET_PC=32'hFFFF_FFFC, with one fetch completed. Required response: inst_pc_o=0xFFFF_FFFC, pc_o=0x0000_0000.
- Misaligned redirect to 0x0000_0106. Required response: fetch_misalign_o pulses for exactly 1 cycle, and the next request goes to 0x0000_0104. Also assert reset mid-WAIT: the state returns to IDLE with pc=RESET_PC, and a late rvalid is ignored.
